// File: rtl/de1_io_pkg.sv
// de1_io_pkg: shared DE1-SoC input sizes, default debounce length and iPort field positions.
package de1_io_pkg;
  localparam int N_SW = 10;
  localparam int N_KEY = 3;
  localparam int DEBOUNCE_CYCLES = 500000;
  localparam int SW_LSB = 0;
  localparam int KEY_LSB = 10;
  localparam int EVT_LSB = 13;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchroniser, qualification counter and stable register for one active-high input.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES),
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  logic [1:0] sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic stable_q, stable_d;
  logic differ, done;
  always_comb begin
    sync_d = {sync_q[0], din};
    differ = sync_q[1] != stable_q;
    done = differ && cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);
    cnt_d = (!differ || done) ? '0 : cnt_q + 1'b1;
    stable_d = done ? sync_q[1] : stable_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {2{RESET_VAL}};
      cnt_q <= '0;
      stable_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      stable_q <= stable_d;
    end
  end
  assign dout = stable_q;
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: debounces DE1-SoC switches/keys and packs them into iPort.
// Sticky key-press flags are built only when INPUT_DEBOUNCER_EVENT_EN is defined.
module input_debouncer #(
  parameter int N_SW = de1_io_pkg::N_SW,
  parameter int N_KEY = de1_io_pkg::N_KEY,
  parameter int DEBOUNCE_CYCLES = de1_io_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [N_SW-1:0]  raw_sw,
  input  logic [N_KEY-1:0] raw_key,
  input  logic [N_KEY-1:0] event_clear,
  output logic [N_SW-1:0]  sw_clean,
  output logic [N_KEY-1:0] key_pressed,
  output logic [N_KEY-1:0] key_event,
  output logic [31:0]      iPort
);
  import de1_io_pkg::*;
  logic [N_SW+N_KEY-1:0] raw_all, clean_all;
  assign raw_all = {~raw_key, raw_sw};
  for (genvar i = 0; i < N_SW + N_KEY; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W),
      .RESET_VAL(1'b0)
    ) u_db (
      .clk(HCLK),
      .rst(HRESET),
      .din(raw_all[i]),
      .dout(clean_all[i])
    );
  end
  assign sw_clean = clean_all[N_SW-1:0];
  assign key_pressed = clean_all[N_SW +: N_KEY];
`ifdef INPUT_DEBOUNCER_EVENT_EN
  logic [N_KEY-1:0] prev_q, prev_d, evt_q, evt_d;
  // A new press outranks a simultaneous clear so no press is lost.
  always_comb begin
    prev_d = key_pressed;
    evt_d = (evt_q & ~event_clear) | (key_pressed & ~prev_q);
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      prev_q <= '0;
      evt_q <= '0;
    end else begin
      prev_q <= prev_d;
      evt_q <= evt_d;
    end
  end
  assign key_event = evt_q;
`else
  logic unused_clear;
  assign unused_clear = ^event_clear;
  assign key_event = '0;
`endif
  always_comb begin
    iPort = '0;
    iPort[SW_LSB +: N_SW] = sw_clean;
    iPort[KEY_LSB +: N_KEY] = key_pressed;
    iPort[EVT_LSB +: N_KEY] = key_event;
  end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed self-checking bench with DEBOUNCE_CYCLES=4.
module tb_input_debouncer;
  logic HCLK = 1'b0;
  logic HRESET;
  logic [9:0] raw_sw;
  logic [2:0] raw_key;
  logic [2:0] event_clear;
  logic [9:0] sw_clean;
  logic [2:0] key_pressed;
  logic [2:0] key_event;
  logic [31:0] iPort;
  int checks = 0;
  int failures = 0;
`ifdef INPUT_DEBOUNCER_EVENT_EN
  localparam logic [2:0] EV = 3'b100;
`else
  localparam logic [2:0] EV = 3'b000;
`endif

  input_debouncer #(.N_SW(10), .N_KEY(3), .DEBOUNCE_CYCLES(4), .CNT_W(2)) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .raw_sw(raw_sw),
    .raw_key(raw_key),
    .event_clear(event_clear),
    .sw_clean(sw_clean),
    .key_pressed(key_pressed),
    .key_event(key_event),
    .iPort(iPort)
  );

  always #5 HCLK = ~HCLK;

  task automatic step(input int n);
    repeat (n) @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    HRESET = 1'b1;
    raw_sw = '0;
    raw_key = 3'b111;
    event_clear = '0;
    step(2);
    chk("rst_sw", 32'(sw_clean), 32'h0);
    chk("rst_key", 32'(key_pressed), 32'h0);
    chk("rst_evt", 32'(key_event), 32'h0);
    chk("rst_iport", iPort, 32'h0);
    HRESET = 1'b0;
    raw_sw = 10'h001;
    step(5);
    chk("sw_step_early", 32'(sw_clean), 32'h0);
    step(1);
    chk("sw_step", 32'(sw_clean), 32'h001);
    chk("sw_step_iport", iPort, 32'h0000_0001);
    for (int r = 0; r < 3; r++) begin
      raw_sw[3] = 1'b1;
      for (int c = 0; c < 3; c++) begin
        step(1);
        chk("glitch_hi", 32'(sw_clean), 32'h001);
      end
      raw_sw[3] = 1'b0;
      for (int c = 0; c < 3; c++) begin
        step(1);
        chk("glitch_lo", 32'(sw_clean), 32'h001);
      end
    end
    raw_sw = '0;
    step(8);
    chk("sw_release", 32'(sw_clean), 32'h0);
    raw_key = 3'b011;
    step(5);
    chk("key_early", 32'(key_pressed), 32'h0);
    step(1);
    chk("key_press", 32'(key_pressed), 32'h4);
    chk("key_evt_not_yet", 32'(key_event), 32'h0);
    chk("key_iport_pre", iPort, 32'h0000_1000);
    step(1);
    chk("key_evt", 32'(key_event), 32'(EV));
    chk("key_iport", iPort, 32'h1000 | (32'(EV) << 13));
    event_clear = 3'b100;
    step(1);
    event_clear = 3'b000;
    chk("evt_clear", 32'(key_event), 32'h0);
    raw_key = 3'b111;
    step(6);
    chk("key_release", 32'(key_pressed), 32'h0);
    chk("release_no_evt", 32'(key_event), 32'h0);
    raw_key = 3'b011;
    step(6);
    chk("repress", 32'(key_pressed), 32'h4);
    chk("repress_evt_pre", 32'(key_event), 32'h0);
    event_clear = 3'b100;
    step(1);
    chk("race_set_wins", 32'(key_event), 32'(EV));
    step(1);
    chk("clear_held", 32'(key_event), 32'h0);
    event_clear = 3'b000;
    raw_key = 3'b111;
    raw_sw = 10'h001;
    step(4);
    HRESET = 1'b1;
    step(1);
    chk("midrst_sw", 32'(sw_clean), 32'h0);
    chk("midrst_key", 32'(key_pressed), 32'h0);
    chk("midrst_evt", 32'(key_event), 32'h0);
    chk("midrst_iport", iPort, 32'h0);
    HRESET = 1'b0;
    step(5);
    chk("requal_early", 32'(sw_clean), 32'h0);
    step(1);
    chk("requal", 32'(sw_clean), 32'h001);
    chk("requal_iport", iPort, 32'h0000_0001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/input_debouncer.md
# input_debouncer

Input-conditioning stage that sits directly upstream of the SoC's `iPort` on the DE1-SoC board. It synchronises and debounces the 10 slide switches and 3 push-buttons, converts the active-low keys to active-high levels, and optionally latches key-press events until software clears them. The packed result drives `iPort` in place of the raw switch wiring.

## Interface
Parameters:
- `N_SW`, 10: number of slide-switch inputs.
- `N_KEY`, 3: number of push-button inputs.
- `DEBOUNCE_CYCLES`, 500000: stable cycles required before an output changes (10 ms at 50 MHz); minimum 2.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES)`: width of the per-input counter.

Ports:
- `HCLK` in 1: system clock (50 MHz).
- `HRESET` in 1: reset. Synchronous, active-high.
- `raw_sw` in N_SW: asynchronous switch inputs, active-high.
- `raw_key` in N_KEY: asynchronous key inputs, active-low.
- `event_clear` in N_KEY: one-cycle pulse per bit that clears the matching `key_event`.
- `sw_clean` out N_SW: debounced switch levels.
- `key_pressed` out N_KEY: debounced key levels, 1 = pressed.
- `key_event` out N_KEY: sticky press flags.
- `iPort` out 32: packed word for the SoC.
  - `[9:0]` = `sw_clean`
  - `[12:10]` = `key_pressed`
  - `[15:13]` = `key_event`
  - `[31:16]` = 0

## Operation
- Each input has its own chain: 2-flop synchroniser, then a counter, then a stable register.
- Key inputs are inverted before the synchroniser, so all internal logic is active-high.
- Counter rules, each cycle:
  - If the synchroniser output equals the stable value, the counter is cleared to 0.
  - Otherwise the counter increments.
  - When the counter is at `DEBOUNCE_CYCLES-1` and the input still differs, the stable register takes the synchroniser value and the counter clears.
  - The counter never wraps.
- Any excursion shorter than `DEBOUNCE_CYCLES` cycles at the synchroniser output is rejected completely.
- `key_event[i]`:
  - Set on the cycle after `key_pressed[i]` goes 0→1.
  - Cleared by `event_clear[i]`.
  - If set and clear happen in the same cycle, set wins, so no press is lost.
  - Release edges never set it.
- Reset values, all applied synchronously:
  - Synchroniser and stable registers for switches: 0.
  - Synchroniser and stable registers for keys: 0, meaning released after inversion.
  - All counters: 0.
  - `key_event`: 0.
  - `iPort`: 0.
- Reset asserted mid-count discards any partial count. An input already held high for a switch is re-qualified after reset, taking the full `DEBOUNCE_CYCLES+2` cycles.

## Timing
- A clean step on a raw input reaches its output exactly `DEBOUNCE_CYCLES+2` rising edges after it is first sampled:
  - 2 cycles for the synchroniser.
  - `DEBOUNCE_CYCLES` cycles of qualification.
- `key_event` rises 1 cycle after `key_pressed`.
- `iPort` is a combinational pack of registered outputs and adds no extra latency.
- All outputs are registered or derive from registers only, so no raw input reaches an output combinationally.
- `event_clear` is sampled on `HCLK`. Holding it high keeps the flag clear, except in a cycle where a set occurs.

## Configuration
- `INPUT_DEBOUNCER_EVENT_EN` defined:
  - `key_event` logic is present.
  - `iPort[15:13]` carries the event flags.
- Macro undefined:
  - Event registers are not built.
  - `key_event` is tied to 0.
  - `event_clear` is ignored.
  - `iPort[15:13]` = 0.
  - All other behaviour is identical.

## Structure
- Shared package `de1_io_pkg` holds:
  - `N_SW`, `N_KEY` and the default `DEBOUNCE_CYCLES`.
  - The `iPort` field positions: `SW_LSB`=0, `KEY_LSB`=10, `EVT_LSB`=13.
- One sub-module, `debounce_bit`: synchroniser, counter and stable register for a single active-high input, with parameters `DEBOUNCE_CYCLES` and `RESET_VAL`. It is instantiated `N_SW+N_KEY` times in a generate loop.
- The top level contains the key inversion, the event flags and the `iPort` packing.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 in simulation.
- **Switch step:** reset, then `raw_sw`=10'h001 held → `sw_clean`=10'h001 exactly 6 edges after first sample; `iPort`=32'h0000_0001.
- **Glitch rejection:** `raw_sw[3]` pulses high for 3 cycles, repeated with 3-cycle gaps → `sw_clean[3]` stays 0 throughout.
- **Key press:** `raw_key`=3'b011 held → `key_pressed`=3'b100 after 6 edges; `key_event`=3'b100 one cycle later; `iPort`=32'h0000_9000.
- **Event clear race:**
  - `event_clear[2]` pulses alone → `key_event[2]`=0 next cycle.
  - Re-press `raw_key[2]` timed so the set coincides with `event_clear[2]` → `key_event[2]`=1.
- **Reset mid-operation:** `HRESET` asserted 2 cycles into qualifying `raw_sw[0]`=1 → all outputs 0 on the next edge; `sw_clean[0]` rises 6 edges after `HRESET` deasserts.
- **Macro off:** build without `INPUT_DEBOUNCER_EVENT_EN` and repeat the key-press scenario → `key_event`=0 and `iPort`=32'h0000_1000.
